oam_dma_controller: RTL and testbench
=====================================

# oam_dma_controller

Sprite DMA sequencer for the NES core. It sits between the CPU bus and the PPU register port. A CPU write to $4014 halts the CPU, and the block takes over the bus. It then copies 256 bytes from CPU page $XX00–$XXFF into PPU OAM through repeated writes to OAMDATA ($2004), and releases the bus with 2A03-accurate cycle counts of 513 or 514.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer
- OAMDATA_ADDR, 16'h2004, PPU OAMDATA register address targeted by DMA writes

Ports:
- i_clk  input  1  CPU clock; all state updates on falling edge
- i_reset_n  input  1  reset, asynchronous, active-low
- i_address  input  16  CPU address bus, used for trigger detect
- i_rw  input  1  CPU read/~write (1 = read)
- i_data  input  8  CPU write data; page number on trigger
- i_bus_data  input  8  read data returned from memory during DMA read cycles
- o_halt  output  1  1 = CPU stalled; the system uses this to mux the bus to DMA
- o_address  output  16  DMA bus address; 0 when idle
- o_rw  output  1  DMA read/~write; 1 when idle
- o_data  output  8  DMA write data; 0 except during write cycles
- o_busy  output  1  transfer in progress; equals o_halt
- o_debug_count  output  8  current byte index
- o_debug_page  output  8  latched source page

## Operation
- The parity register r_put toggles every clock from reset (reset 0). r_put = 0 marks a "get" cycle and r_put = 1 marks a "put" cycle.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - Trigger when o_halt = 0, i_rw = 0 and i_address == DMA_REG_ADDR.
  - On trigger, latch page ← i_data and count ← 0, then go to HALT.
- HALT: one dummy cycle with no bus activity (o_rw = 1, o_address = 0).
  - If the next cycle is a get cycle, go to READ.
  - Otherwise go to ALIGN.
- ALIGN: one dummy cycle, then READ. READ is therefore always on a get cycle.
- READ: o_address = {page, count}, o_rw = 1. Latch i_bus_data into r_byte at the end of the cycle, then go to WRITE.
- WRITE: o_address = OAMDATA_ADDR, o_rw = 0, o_data = r_byte. count ← count + 1 (8-bit).
  - If count was 255, go to IDLE.
  - Otherwise go to READ.
- o_halt = 1 in HALT, ALIGN, READ and WRITE.
- A write to DMA_REG_ADDR while busy is ignored: no relatch, no restart.
- Page $FF reads $FF00–$FFFF. The address never carries into bit 16; count wraps only on termination.
- The PPU side needs no changes. Each WRITE cycle is an ordinary OAMDATA write, so the PPU's OAMADDR auto-increments. Transfers start at the current OAMADDR and wrap within OAM.

## Timing
- Reset values:
  - State IDLE.
  - o_halt = 0, o_busy = 0.
  - o_address = 0, o_rw = 1, o_data = 0.
  - count = 0, page = 0, r_byte = 0, r_put = 0.
- Trigger write cycle = T0.
  - HALT is cycle T0+1.
  - The first READ is at T0+2, or at T0+3 when ALIGN is inserted.
- Total halted cycles:
  - 513 when the HALT cycle is a put cycle (no ALIGN).
  - 514 when the HALT cycle is a get cycle (ALIGN inserted).
- Read-to-write latency is 1 cycle. Byte n is read at cycle R+2n and written at R+2n+1, where R is the first READ cycle.
- o_halt falls in the cycle after the final WRITE. The CPU resumes on that cycle, and a new trigger is accepted from then on.
- Reset asserted mid-transfer:
  - Return to IDLE immediately (asynchronously) and drop o_halt.
  - Any partially written OAM contents are left as is.
  - No resume after reset release.
- All outputs are registered or decoded from state only. There is no combinational path from i_address or i_data to o_address.

## Test plan
- Even-aligned trigger:
  - Stimulus: write $02 to $4014 with the HALT cycle on a put cycle; memory $0200+n = n^$A5.
  - Required: o_halt high for exactly 513 cycles; 256 writes to $2004 carrying n^$A5 in order; first read address $0200, last $02FF.
- Odd-aligned trigger:
  - Stimulus: same transfer with the trigger shifted by one cycle.
  - Required: one ALIGN cycle (o_rw = 1, o_address = 0); 514 halted cycles; identical data sequence.
- Page wrap:
  - Stimulus: page $FF.
  - Required: reads span $FF00–$FFFF and no address reaches $0000; after the last write, o_halt = 0, state is IDLE and count = 0.
- Retrigger while busy:
  - Stimulus: force i_rw = 0, i_address = $4014, i_data = $07 at byte 100.
  - Required: page stays $02; the transfer completes unchanged in 513/514 cycles.
- Reset mid-transfer:
  - Stimulus: assert i_reset_n low at byte 40.
  - Required: o_halt = 0, o_address = 0, o_rw = 1 immediately.
  - Then: a subsequent $4014 write of $03 runs a full, correct transfer from $0300.
- Integration with PPU:
  - Stimulus: set OAMADDR = $10, then DMA from page $02.
  - Required: OAM[$10] = mem[$0200] and OAM[$0F] = mem[$02FF]; OAMADDR returns to $10.

Source files
------------

// File: rtl/oam_dma_controller.sv
`default_nettype none
// ============================================================================
//  Module   : oam_dma_controller
//  Purpose  : Sprite DMA sequencer. A CPU write to DMA_REG_ADDR halts the CPU.
//             The block then copies 256 bytes from page {i_data,8'h00} into PPU
//             OAM by repeated writes to OAMDATA_ADDR. It then releases the bus,
//             for 513 or 514 halted cycles depending on get/put alignment.
//  Ports    : i_clk          CPU clock; state advances on the falling edge
//             i_reset_n      asynchronous active-low reset
//             i_address      CPU address bus (trigger detect)
//             i_rw           CPU read/~write (1 = read)
//             i_data         CPU write data (page number on trigger)
//             i_bus_data     memory read data during DMA read cycles
//             o_halt         CPU stall / bus-mux select
//             o_address      DMA bus address (0 when idle)
//             o_rw           DMA read/~write (1 when idle)
//             o_data         DMA write data (0 outside write cycles)
//             o_busy         transfer in progress (same as o_halt)
//             o_debug_count  current byte index
//             o_debug_page   latched source page
//  Revision : 1.0 - initial release
// ============================================================================
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_address,
  input  logic        i_rw,
  input  logic [7:0]  i_data,
  input  logic [7:0]  i_bus_data,
  output logic        o_halt,
  output logic [15:0] o_address,
  output logic        o_rw,
  output logic [7:0]  o_data,
  output logic        o_busy,
  output logic [7:0]  o_debug_count,
  output logic [7:0]  o_debug_page
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_put;     // 0 = get cycle, 1 = put cycle
  logic [7:0]  r_page;
  logic [7:0]  r_count;
  logic [7:0]  r_byte;
  logic        w_trigger;

  // Only an idle controller reacts; a write to the trigger register while busy
  // is ignored so the running transfer is neither relatched nor restarted.
  assign w_trigger = (r_state == S_IDLE) && !i_rw && (i_address == DMA_REG_ADDR);

  // State register and datapath, all advancing on the falling clock edge.
  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_put   <= 1'b0;
      r_page  <= 8'h00;
      r_count <= 8'h00;
      r_byte  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_put   <= ~r_put;
      if (w_trigger) begin
        r_page  <= i_data;
        r_count <= 8'h00;
      end
      if (r_state == S_READ) begin
        r_byte <= i_bus_data;
      end
      if (r_state == S_WRITE) begin
        // Wraps back to 0 exactly when the final byte has been written.
        r_count <= r_count + 8'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trigger) w_state_next = S_HALT;
      // The cycle after HALT has the opposite parity; if HALT is a put cycle
      // the next one is a get cycle and reading can start immediately.
      S_HALT:  w_state_next = r_put ? S_READ : S_ALIGN;
      S_ALIGN: w_state_next = S_READ;
      S_READ:  w_state_next = S_WRITE;
      S_WRITE: w_state_next = (r_count == 8'hFF) ? S_IDLE : S_READ;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bus outputs decoded from state and internal registers only, so there is
  // no combinational path from the CPU bus inputs to the DMA bus outputs.
  always_comb begin
    o_address = 16'h0000;
    o_rw      = 1'b1;
    o_data    = 8'h00;
    case (r_state)
      S_READ: begin
        o_address = {r_page, r_count};
      end
      S_WRITE: begin
        o_address = OAMDATA_ADDR;
        o_rw      = 1'b0;
        o_data    = r_byte;
      end
      default: begin
        o_address = 16'h0000;
      end
    endcase
  end

  assign o_halt        = (r_state != S_IDLE);
  assign o_busy        = o_halt;
  assign o_debug_count = r_count;
  assign o_debug_page  = r_page;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oam_dma_controller
//  Purpose  : Scoreboard bench for oam_dma_controller. Stimulus pushes the
//             expected read addresses, write bytes, halt length and dummy-cycle
//             count of each transfer; a monitor pops and compares them as the
//             DMA bus activity appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_data;
  logic [7:0]  bus_data;
  logic        o_halt;
  logic [15:0] o_address;
  logic        o_rw;
  logic [7:0]  o_data;
  logic        o_busy;
  logic [7:0]  o_debug_count;
  logic [7:0]  o_debug_page;

  always #5 clk = ~clk;

  oam_dma_controller dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_address     (cpu_addr),
    .i_rw          (cpu_rw),
    .i_data        (cpu_data),
    .i_bus_data    (bus_data),
    .o_halt        (o_halt),
    .o_address     (o_address),
    .o_rw          (o_rw),
    .o_data        (o_data),
    .o_busy        (o_busy),
    .o_debug_count (o_debug_count),
    .o_debug_page  (o_debug_page)
  );

  // Memory image: page $02 holds n^$A5, other pages a different pattern.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  always_comb bus_data = mem_byte(o_address);

  // Get/put parity reference: 0 at reset, toggles every falling edge.
  logic tb_put;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) tb_put <= 1'b0;
    else        tb_put <= ~tb_put;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Scoreboard queues.
  logic [15:0] q_rd[$];
  logic [7:0]  q_wr[$];
  int          q_len[$];
  int          q_dummy[$];

  // OAM model of the PPU side.
  logic [7:0] oam [256];
  logic [7:0] oamaddr = 8'h00;

  int halt_run  = 0;
  int dummy_run = 0;
  int wr_idx    = 0;

  // Monitor: samples on the rising edge, opposite the DUT's active edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      halt_run  = 0;
      dummy_run = 0;
      wr_idx    = 0;
    end else begin
      check("busy_eq_halt", {31'd0, o_busy}, {31'd0, o_halt});
      if (o_halt) begin
        halt_run++;
        if (o_rw && o_address == 16'h0000) begin
          dummy_run++;
        end else if (o_rw) begin
          if (q_rd.size() == 0) flag_fail("rd_unexpected");
          else check("rd_addr", {16'd0, o_address}, {16'd0, q_rd.pop_front()});
        end else begin
          check("wr_addr", {16'd0, o_address}, 32'h2004);
          if (q_wr.size() == 0) flag_fail("wr_unexpected");
          else check("wr_data", {24'd0, o_data}, {24'd0, q_wr.pop_front()});
          oam[oamaddr] = o_data;
          oamaddr      = oamaddr + 8'd1;
          wr_idx++;
        end
      end else begin
        check("idle_addr", {16'd0, o_address}, 32'h0);
        check("idle_rw",   {31'd0, o_rw},      32'h1);
        if (halt_run != 0) begin
          if (q_len.size() == 0) flag_fail("halt_unexpected");
          else check("halt_len", halt_run, q_len.pop_front());
          if (q_dummy.size() != 0) check("dummy_cycles", dummy_run, q_dummy.pop_front());
          halt_run  = 0;
          dummy_run = 0;
          wr_idx    = 0;
        end
      end
    end
  end

  // Issue a $4014 write. align=0 puts HALT on a put cycle (513 halted cycles);
  // align=1 puts HALT on a get cycle (ALIGN inserted, 514 cycles).
  task automatic trigger(input logic [7:0] page, input bit align);
    @(posedge clk); #1;
    while (tb_put != align) begin
      @(posedge clk); #1;
    end
    cpu_addr = 16'h4014;
    cpu_rw   = 1'b0;
    cpu_data = page;
    for (int n = 0; n < 256; n++) begin
      q_rd.push_back({page, n[7:0]});
      q_wr.push_back(mem_byte({page, n[7:0]}));
    end
    q_len.push_back(align ? 514 : 513);
    q_dummy.push_back(align ? 2 : 1);
    @(posedge clk); #1;
    cpu_addr = 16'h0000;
    cpu_rw   = 1'b1;
    cpu_data = 8'h00;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (q_len.size() == 0 && !o_halt) begin
        check({name, "_rd_left"}, q_rd.size(), 0);
        check({name, "_wr_left"}, q_wr.size(), 0);
        return;
      end
    end
    flag_fail({name, "_timeout"});
  endtask

  task automatic wait_byte(input int idx);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (wr_idx >= idx) return;
    end
    flag_fail("wait_byte_timeout");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    cpu_addr = 16'h0000;
    cpu_rw   = 1'b1;
    cpu_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_halt",  {31'd0, o_halt},        32'h0);
    check("rst_busy",  {31'd0, o_busy},        32'h0);
    check("rst_addr",  {16'd0, o_address},     32'h0);
    check("rst_rw",    {31'd0, o_rw},          32'h1);
    check("rst_data",  {24'd0, o_data},        32'h0);
    check("rst_count", {24'd0, o_debug_count}, 32'h0);
    check("rst_page",  {24'd0, o_debug_page},  32'h0);
    #1 rst_n = 1'b1;

    // Even-aligned transfer from page $02.
    trigger(8'h02, 1'b0);
    wait_done("even");
    check("even_count", {24'd0, o_debug_count}, 32'h0);
    check("even_page",  {24'd0, o_debug_page},  32'h02);

    // Odd-aligned transfer, ALIGN cycle inserted.
    trigger(8'h02, 1'b1);
    wait_done("odd");

    // Page $FF: reads stay within $FF00-$FFFF.
    trigger(8'hFF, 1'b0);
    wait_done("wrap");
    check("wrap_halt",  {31'd0, o_halt},        32'h0);
    check("wrap_busy",  {31'd0, o_busy},        32'h0);
    check("wrap_count", {24'd0, o_debug_count}, 32'h0);
    check("wrap_page",  {24'd0, o_debug_page},  32'hFF);

    // Retrigger while busy is ignored.
    trigger(8'h02, 1'b1);
    wait_byte(100);
    cpu_addr = 16'h4014;
    cpu_rw   = 1'b0;
    cpu_data = 8'h07;
    repeat (2) @(posedge clk);
    #1;
    cpu_addr = 16'h0000;
    cpu_rw   = 1'b1;
    cpu_data = 8'h00;
    check("retrig_page_mid", {24'd0, o_debug_page}, 32'h02);
    wait_done("retrig");
    check("retrig_page_end", {24'd0, o_debug_page}, 32'h02);

    // Reset mid-transfer, then a fresh transfer from page $03.
    trigger(8'h02, 1'b0);
    wait_byte(40);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_halt", {31'd0, o_halt},    32'h0);
    check("mrst_addr", {16'd0, o_address}, 32'h0);
    check("mrst_rw",   {31'd0, o_rw},      32'h1);
    q_rd.delete();
    q_wr.delete();
    q_len.delete();
    q_dummy.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mrst_no_resume", {31'd0, o_halt}, 32'h0);
    trigger(8'h03, 1'b0);
    wait_done("page3");
    check("page3_page", {24'd0, o_debug_page}, 32'h03);

    // PPU integration: transfer starts at OAMADDR $10 and wraps within OAM.
    oamaddr = 8'h10;
    trigger(8'h02, 1'b0);
    wait_done("ppu");
    check("oam_10", {24'd0, oam[8'h10]}, 32'hA5);
    check("oam_0f", {24'd0, oam[8'h0F]}, 32'h5A);
    check("oamaddr_end", {24'd0, oamaddr}, 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
